// File: rtl/uart_rx_sink.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_sink
//  Brief    : 8N1 UART receiver that deserialises a TX line into bytes,
//             queues them in a small FIFO and hands them out over a
//             valid/ready stream. Flags framing errors and FIFO overflow.
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx_sink #(
    parameter int CLK_DIV    = 868,  // clock cycles per bit
    parameter int FIFO_DEPTH = 8     // power of two, >= 2
) (
    input  logic        clock,
    input  logic        reset,       // synchronous, active-low
    input  logic        rx,
    output logic        out_valid,
    output logic [7:0]  out_data,
    input  logic        out_ready,
    output logic        frame_err,
    output logic        overflow,
    output logic [31:0] byte_count
);

    localparam int CW = $clog2(CLK_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] c_CNT_HALF = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] c_CNT_FULL = CW'(CLK_DIV - 1);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_START = 3'd1;
    localparam logic [2:0] c_DATA  = 3'd2;
    localparam logic [2:0] c_STOP  = 3'd3;
    localparam logic [2:0] c_BREAK = 3'd4;

    logic            r_rx_m;
    logic            r_rx_s;
    logic            r_rx_d;
    logic [1:0]      r_sync_cnt;
    logic            r_armed;
    logic [2:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bitn;
    logic [7:0]      r_shreg;
    logic            r_frame_err;
    logic [7:0]      r_mem [FIFO_DEPTH];
    logic [AW:0]     r_wr_ptr;
    logic [AW:0]     r_rd_ptr;
    logic            r_overflow;
    logic [31:0]     r_byte_count;

    logic            w_sync_live;
    logic            w_fall;
    logic            w_cnt_zero;
    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_full;
    logic            w_accept;

    // Two-flop synchroniser plus a history flop for edge detection.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
            r_rx_d <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
            r_rx_d <= r_rx_s;
        end
    end

    // The preset synchroniser values are not line samples; the receiver is
    // only armed once a genuine idle-high level has reached r_rx_s, so a line
    // already low at reset release cannot masquerade as a start edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_sync_cnt <= 2'd0;
            r_armed    <= 1'b0;
        end else begin
            if (r_sync_cnt != 2'd2) begin
                r_sync_cnt <= r_sync_cnt + 2'd1;
            end
            if (w_sync_live && r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sync_live = (r_sync_cnt == 2'd2);
    assign w_fall      = r_armed && r_rx_d && !r_rx_s;
    assign w_cnt_zero  = (r_cnt == '0);

    // Frame state machine: start-bit validation, data shifting, stop check.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_bitn      <= 3'd0;
            r_shreg     <= 8'd0;
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_fall) begin
                        r_cnt   <= c_CNT_HALF;
                        r_state <= c_START;
                    end
                end
                c_START: begin
                    if (w_cnt_zero) begin
                        if (!r_rx_s) begin
                            r_cnt   <= c_CNT_FULL;
                            r_bitn  <= 3'd0;
                            r_state <= c_DATA;
                        end else begin
                            r_state <= c_IDLE;   // too short: line glitch
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_DATA: begin
                    if (w_cnt_zero) begin
                        r_shreg <= {r_rx_s, r_shreg[7:1]};
                        r_cnt   <= c_CNT_FULL;
                        if (r_bitn == 3'd7) begin
                            r_state <= c_STOP;
                        end else begin
                            r_bitn <= r_bitn + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_STOP: begin
                    if (w_cnt_zero) begin
                        if (r_rx_s) begin
                            r_state <= c_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= c_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                c_BREAK: begin
                    // Hold here for the whole break so it reports only once.
                    if (r_rx_s) begin
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign w_push   = (r_state == c_STOP) && w_cnt_zero && r_rx_s;
    assign w_empty  = (r_wr_ptr == r_rd_ptr);
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_pop    = !w_empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_accept = w_push && (!w_full || w_pop);

    // Byte storage; contents need no reset since out_data is gated by valid.
    always_ff @(posedge clock) begin
        if (w_accept) begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_shreg;
        end
    end

    // FIFO pointers, sticky overflow flag and accepted-byte counter.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_overflow   <= 1'b0;
            r_byte_count <= 32'd0;
        end else begin
            if (w_accept) begin
                r_wr_ptr     <= r_wr_ptr + 1'b1;
                r_byte_count <= r_byte_count + 32'd1;
            end else if (w_push) begin
                r_overflow <= 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    assign out_valid  = !w_empty;
    assign out_data   = w_empty ? 8'd0 : r_mem[r_rd_ptr[AW-1:0]];
    assign frame_err  = r_frame_err;
    assign overflow   = r_overflow;
    assign byte_count = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_sink.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_sink
//  Brief    : Self-checking bench for uart_rx_sink (CLK_DIV=16, FIFO_DEPTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_uart_rx_sink;

    localparam int CLK_DIV    = 16;
    localparam int FIFO_DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        frame_err;
    logic        overflow;
    logic [31:0] byte_count;

    always #5 clock = ~clock;

    uart_rx_sink #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .rx         (rx),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .byte_count (byte_count)
    );

    int checks   = 0;
    int failures = 0;
    int rd_idx   = 0;

    // Observations gathered by the monitor; only the monitor writes these.
    logic [7:0] got_q[$];
    int         cyc            = 0;
    int         valid_rise_cyc = 0;
    int         valid_cycles   = 0;
    int         ferr_pulses    = 0;
    int         stab_err       = 0;
    logic       prev_valid     = 1'b0;
    logic       prev_hold      = 1'b0;
    logic [7:0] prev_data      = 8'd0;

    always @(negedge clock) begin
        cyc        <= cyc + 1;
        prev_valid <= out_valid;
        if (out_valid && !prev_valid) valid_rise_cyc <= cyc + 1;
        if (out_valid) valid_cycles <= valid_cycles + 1;
        if (reset && frame_err) ferr_pulses <= ferr_pulses + 1;
        if (reset && out_valid && out_ready) got_q.push_back(out_data);
        if (prev_hold && out_valid && (out_data !== prev_data)) stab_err <= stab_err + 1;
        prev_hold <= reset && out_valid && !out_ready;
        prev_data <= out_data;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        int         stop_len;
        bit         exp_push;
        int         exp_ferr;
    } vec_t;

    vec_t vecs[6];

    task automatic tick(input int n);
        if (n > 0) begin
            repeat (n) @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end
    endtask

    // Drive one 8N1 frame; a bad stop bit is held low for stop_len cycles.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int stop_len);
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            tick(CLK_DIV);
        end
        rx = stop_ok;
        tick(stop_ok ? CLK_DIV : stop_len);
        rx = 1'b1;
    endtask

    task automatic expect_byte(input string name, input logic [7:0] b);
        int t;
        t = 0;
        while (got_q.size() <= rd_idx && t < 400) begin
            tick(1);
            t++;
        end
        if (got_q.size() <= rd_idx) begin
            checks++;
            failures++;
            $display("FAIL %s got=none required=%02h", name, b);
        end else begin
            chk(name, {24'd0, got_q[rd_idx]}, {24'd0, b});
            rd_idx++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(3);
        reset = 1'b1;
        tick(4);
        rd_idx = got_q.size();
    endtask

    initial begin
        int         s;
        int         lat;
        int         v0;
        int         f0;
        int         bc_exp;
        int         n_good;
        int         n_bad;
        bit         done;
        logic [7:0] exp_list[$];
        logic [7:0] rb;

        vecs[0] = '{8'h00, 1'b1, 16, 1'b1, 0};
        vecs[1] = '{8'hFF, 1'b1, 16, 1'b1, 0};
        vecs[2] = '{8'hA5, 1'b1, 16, 1'b1, 0};
        vecs[3] = '{8'h12, 1'b0, 40, 1'b0, 1};
        vecs[4] = '{8'h34, 1'b1, 16, 1'b1, 0};
        vecs[5] = '{8'h80, 1'b0, 16, 1'b0, 1};

        // Reset state
        tick(3);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_data", {24'd0, out_data}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_count", byte_count, 32'd0);
        reset = 1'b1;
        tick(4);

        // Single byte 0x55: latency, one-cycle valid, counters
        out_ready = 1'b1;
        s  = cyc;
        v0 = valid_cycles;
        f0 = ferr_pulses;
        send_frame(8'h55, 1'b1, 0);
        tick(20);
        expect_byte("byte_55", 8'h55);
        lat = valid_rise_cyc - s;
        checks++;
        if (lat < 150 || lat > 162) begin
            failures++;
            $display("FAIL lat_55 got=%0d required=150..162", lat);
        end
        chk("valid_len_55", valid_cycles - v0, 32'd1);
        chk("count_55", byte_count, 32'd1);
        chk("ferr_55", ferr_pulses - f0, 32'd0);
        bc_exp = 1;

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            f0 = ferr_pulses;
            send_frame(vecs[i].data, vecs[i].stop_ok, vecs[i].stop_len);
            if (!vecs[i].stop_ok) tick(CLK_DIV);
            tick(20);
            if (vecs[i].exp_push) begin
                expect_byte($sformatf("vec%0d_data", i), vecs[i].data);
                bc_exp++;
            end
            chk($sformatf("vec%0d_count", i), byte_count, bc_exp);
            chk($sformatf("vec%0d_ferr", i), ferr_pulses - f0, vecs[i].exp_ferr);
        end
        tick(200);
        chk("vec_no_extra", got_q.size(), rd_idx);

        // Overflow: five back-to-back bytes into a 4-deep FIFO
        do_reset();
        out_ready = 1'b0;
        send_frame(8'hA5, 1'b1, 0);
        send_frame(8'h3C, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        send_frame(8'h00, 1'b1, 0);
        send_frame(8'h81, 1'b1, 0);
        tick(20);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", byte_count, 32'd4);
        chk("ovf_head", {24'd0, out_data}, 32'hA5);
        chk("ovf_no_pop", got_q.size(), rd_idx);
        out_ready = 1'b1;
        expect_byte("ovf_b0", 8'hA5);
        expect_byte("ovf_b1", 8'h3C);
        expect_byte("ovf_b2", 8'hFF);
        expect_byte("ovf_b3", 8'h00);
        tick(5);
        chk("ovf_drained", {31'd0, out_valid}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("hold_stable", stab_err, 32'd0);

        // Short glitch on an idle line
        do_reset();
        f0 = ferr_pulses;
        rx = 1'b0;
        tick(5);
        rx = 1'b1;
        tick(200);
        chk("glitch_ferr", ferr_pulses - f0, 32'd0);
        chk("glitch_count", byte_count, 32'd0);
        chk("glitch_nopush", got_q.size(), rd_idx);
        send_frame(8'h5A, 1'b1, 0);
        expect_byte("glitch_after", 8'h5A);

        // Pop coincident with a push into a full FIFO
        do_reset();
        out_ready = 1'b0;
        send_frame(8'h11, 1'b1, 0);
        send_frame(8'h22, 1'b1, 0);
        send_frame(8'h33, 1'b1, 0);
        send_frame(8'h44, 1'b1, 0);
        tick(10);
        chk("full_count", byte_count, 32'd4);
        fork
            send_frame(8'h55, 1'b1, 0);
            begin
                tick(154);
                out_ready = 1'b1;
                tick(1);
                out_ready = 1'b0;
            end
        join
        tick(10);
        chk("pp_ovf", {31'd0, overflow}, 32'd0);
        chk("pp_count", byte_count, 32'd5);
        out_ready = 1'b1;
        expect_byte("pp_b0", 8'h11);
        expect_byte("pp_b1", 8'h22);
        expect_byte("pp_b2", 8'h33);
        expect_byte("pp_b3", 8'h44);
        expect_byte("pp_b4", 8'h55);

        // Reset in the middle of frame 0x77 with a byte still queued
        out_ready = 1'b0;
        send_frame(8'h99, 1'b1, 0);
        tick(5);
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1;           // 0x77 bits 0..2
            tick(CLK_DIV);
        end
        rx = 1'b0;               // bit 3, line stays low across reset
        tick(4);
        reset = 1'b0;
        tick(3);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_data", {24'd0, out_data}, 32'd0);
        chk("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        chk("mid_rst_count", byte_count, 32'd0);
        reset = 1'b1;
        f0 = ferr_pulses;
        tick(40);
        rx = 1'b1;
        tick(40);
        rd_idx = got_q.size();
        chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        send_frame(8'h42, 1'b1, 0);
        tick(20);
        expect_byte("post_rst_42", 8'h42);
        tick(200);
        chk("post_rst_count", byte_count, 32'd1);
        chk("post_rst_ferr", ferr_pulses - f0, 32'd0);
        chk("post_rst_only", got_q.size(), rd_idx);

        // Randomised frames against a queue-based reference model
        do_reset();
        f0     = ferr_pulses;
        n_good = 0;
        n_bad  = 0;
        done   = 1'b0;
        exp_list.delete();
        fork
            begin
                for (int i = 0; i < 14; i++) begin
                    rb = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 4) == 0) begin
                        send_frame(rb, 1'b0, int'($urandom_range(16, 48)));
                        n_bad++;
                        tick(CLK_DIV + int'($urandom_range(0, 20)));
                    end else begin
                        send_frame(rb, 1'b1, 0);
                        exp_list.push_back(rb);
                        n_good++;
                        tick(int'($urandom_range(0, 20)));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        out_ready = 1'b1;
        tick(30);
        foreach (exp_list[i]) begin
            expect_byte($sformatf("rand_b%0d", i), exp_list[i]);
        end
        chk("rand_count", byte_count, n_good);
        chk("rand_ferr", ferr_pulses - f0, n_bad);
        chk("rand_ovf", {31'd0, overflow}, 32'd0);
        chk("rand_no_extra", got_q.size(), rd_idx);
        chk("rand_stable", stab_err, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
